// File: rtl/dac8563_spi_rx_decoder_pkg.sv
// Shared definitions for the DAC8563 serial-link responder.
// Contents: frame geometry and field positions, command and address codes,
// decoder FSM state type, default clear code and an address-to-channel helper.
package dac8563_spi_rx_decoder_pkg;

  // Frame layout, MSB first: [23:22] don't-care, [21:19] cmd, [18:16] addr, [15:0] data
  localparam int FRAME_BITS = 24;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);
  localparam int CMD_MSB    = 21;
  localparam int CMD_LSB    = 19;
  localparam int ADDR_MSB   = 18;
  localparam int ADDR_LSB   = 16;
  localparam int DATA_MSB   = 15;
  localparam int DATA_LSB   = 0;
  // Only cmd/addr/data need to be kept; the two leading don't-care bits fall off the top
  localparam int KEEP_BITS  = CMD_MSB + 1;

  localparam logic [15:0] CLR_CODE_DEFAULT = 16'h8000;

  localparam logic [2:0] CMD_WR_IN         = 3'b000;
  localparam logic [2:0] CMD_UPD_DAC       = 3'b001;
  localparam logic [2:0] CMD_WR_IN_UPD_ALL = 3'b010;
  localparam logic [2:0] CMD_WR_UPD        = 3'b011;
  localparam logic [2:0] CMD_PWR           = 3'b100;
  localparam logic [2:0] CMD_SW_RST        = 3'b101;
  localparam logic [2:0] CMD_LDAC_MASK     = 3'b110;
  localparam logic [2:0] CMD_REF           = 3'b111;

  localparam logic [2:0] ADDR_A   = 3'b000;
  localparam logic [2:0] ADDR_B   = 3'b001;
  localparam logic [2:0] ADDR_ALL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DECODE,
    ST_WAIT_HI
  } state_t;

  // Channel select {B,A}; zero for an address that maps to no channel
  function automatic logic [1:0] addr_sel(input logic [2:0] addr);
    case (addr)
      ADDR_A:   addr_sel = 2'b01;
      ADDR_B:   addr_sel = 2'b10;
      ADDR_ALL: addr_sel = 2'b11;
      default:  addr_sel = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/dac8563_spi_rx_decoder_if.sv
// Pin bundle between a DAC8563 serial master and the responder.
// Signals: sync (frame select, low active), sclk (falling-edge data clock),
// mosi (serial data), ldac (low-active load), clr (low-active clear).
// master drives all pins, slave receives them.
interface dac8563_spi_rx_decoder_if;
  logic sync;
  logic sclk;
  logic mosi;
  logic ldac;
  logic clr;

  modport master (output sync, sclk, mosi, ldac, clr);
  modport slave  (input  sync, sclk, mosi, ldac, clr);
endinterface

// File: rtl/dac8563_spi_rx_decoder_sampler.sv
// Synchronisers and edge detection for the asynchronous DAC8563 pins.
// Inputs : clk, rst_n, raw sync/sclk/mosi/ldac/clr pins.
// Outputs: bit_vld (one-cycle SCLK fall), bit_data (MOSI at that fall),
//          sync_hi (synchronised SYNC level), sync_fall (one-cycle SYNC fall),
//          ldac_low / clr_low (synchronised, active-high levels).
module dac8563_spi_rx_decoder_sampler #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sync_pin,
  input  logic sclk_pin,
  input  logic mosi_pin,
  input  logic ldac_pin,
  input  logic clr_pin,
  output logic bit_vld,
  output logic bit_data,
  output logic sync_hi,
  output logic sync_fall,
  output logic ldac_low,
  output logic clr_low
);

  logic [SYNC_STAGES-1:0] sync_pipe, sclk_pipe, mosi_pipe, ldac_pipe, clr_pipe;
  logic                   sync_prev, sclk_prev;
  // Edges are suppressed until the pipes hold real pin samples, so a SYNC that is
  // already low when reset is released is not mistaken for a frame start.
  logic [SYNC_STAGES:0]   settle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_pipe <= '1;
      sclk_pipe <= '1;
      mosi_pipe <= '1;
      ldac_pipe <= '1;
      clr_pipe  <= '1;
      sync_prev <= 1'b1;
      sclk_prev <= 1'b1;
      settle    <= '0;
    end else begin
      sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], sync_pin};
      sclk_pipe <= {sclk_pipe[SYNC_STAGES-2:0], sclk_pin};
      mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], mosi_pin};
      ldac_pipe <= {ldac_pipe[SYNC_STAGES-2:0], ldac_pin};
      clr_pipe  <= {clr_pipe[SYNC_STAGES-2:0], clr_pin};
      sync_prev <= sync_pipe[SYNC_STAGES-1];
      sclk_prev <= sclk_pipe[SYNC_STAGES-1];
      settle    <= {settle[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // MOSI is taken from the same stage as SCLK so both see identical delay
  assign bit_data  = mosi_pipe[SYNC_STAGES-1];
  assign bit_vld   = settle[SYNC_STAGES] & sclk_prev & ~sclk_pipe[SYNC_STAGES-1];
  assign sync_fall = settle[SYNC_STAGES] & sync_prev & ~sync_pipe[SYNC_STAGES-1];
  assign sync_hi   = sync_pipe[SYNC_STAGES-1];
  assign ldac_low  = ~ldac_pipe[SYNC_STAGES-1];
  assign clr_low   = ~clr_pipe[SYNC_STAGES-1];

endmodule

// File: rtl/dac8563_spi_rx_decoder.sv
// DAC8563 serial-link responder: assembles 24-bit frames and keeps a
// register-accurate shadow of the DAC.
// Ports: sys_clk, rst_n (async, low active); spi (slave modport: sync, sclk,
// mosi, ldac, clr); dac_a/dac_b, in_a/in_b (16-bit registers); pd_mode and
// ldac_mask ({B,A}); frame_vld / frame_err one-cycle pulses; frame_cmd,
// frame_addr, frame_data hold the last decoded frame.
module dac8563_spi_rx_decoder
  import dac8563_spi_rx_decoder_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] CLR_CODE    = CLR_CODE_DEFAULT
) (
  input  logic                     sys_clk,
  input  logic                     rst_n,
  dac8563_spi_rx_decoder_if.slave  spi,
  output logic [15:0]              dac_a,
  output logic [15:0]              dac_b,
  output logic [15:0]              in_a,
  output logic [15:0]              in_b,
  output logic [1:0]               pd_mode,
  output logic [1:0]               ldac_mask,
  output logic                     frame_vld,
  output logic [2:0]               frame_cmd,
  output logic [2:0]               frame_addr,
  output logic [15:0]              frame_data,
  output logic                     frame_err
);

  logic bit_vld, bit_data, sync_hi, sync_fall, ldac_low, clr_low;

  dac8563_spi_rx_decoder_sampler #(.SYNC_STAGES(SYNC_STAGES)) u_sampler (
    .clk       (sys_clk),
    .rst_n     (rst_n),
    .sync_pin  (spi.sync),
    .sclk_pin  (spi.sclk),
    .mosi_pin  (spi.mosi),
    .ldac_pin  (spi.ldac),
    .clr_pin   (spi.clr),
    .bit_vld   (bit_vld),
    .bit_data  (bit_data),
    .sync_hi   (sync_hi),
    .sync_fall (sync_fall),
    .ldac_low  (ldac_low),
    .clr_low   (clr_low)
  );

  // ---------------- frame FSM ----------------
  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [KEEP_BITS-1:0] shift_reg, shift_next;
  logic                 err_next;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      shift_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      shift_reg <= shift_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    shift_next = shift_reg;
    err_next   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (sync_fall) begin
          state_next = ST_SHIFT;
          cnt_next   = '0;
          shift_next = '0;
        end
      end
      ST_SHIFT: begin
        // An early SYNC rise abandons the frame; only a frame with bits in it is an error
        if (sync_hi) begin
          state_next = ST_IDLE;
          err_next   = (cnt_reg != '0);
        end else if (bit_vld) begin
          shift_next = {shift_reg[KEEP_BITS-2:0], bit_data};
          cnt_next   = cnt_reg + CNT_W'(1);
          if (cnt_reg == CNT_W'(FRAME_BITS - 1)) state_next = ST_DECODE;
        end
      end
      ST_DECODE:  state_next = ST_WAIT_HI;
      ST_WAIT_HI: if (sync_hi) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // ---------------- frame decode ----------------
  logic        decode_en, addr_ok;
  logic [2:0]  f_cmd, f_addr;
  logic [15:0] f_data;
  logic [1:0]  sel;

  assign decode_en = (state_reg == ST_DECODE);
  assign f_cmd     = shift_reg[CMD_MSB:CMD_LSB];
  assign f_addr    = shift_reg[ADDR_MSB:ADDR_LSB];
  assign f_data    = shift_reg[DATA_MSB:DATA_LSB];
  assign sel       = addr_sel(f_addr);
  assign addr_ok   = |sel;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_vld  <= 1'b0;
      frame_err  <= 1'b0;
      frame_cmd  <= '0;
      frame_addr <= '0;
      frame_data <= '0;
    end else begin
      frame_vld <= decode_en;
      frame_err <= err_next;
      if (decode_en) begin
        frame_cmd  <= f_cmd;
        frame_addr <= f_addr;
        frame_data <= f_data;
      end
    end
  end

  // ---------------- power-down and LDAC mask ----------------
  logic [1:0] pd_reg, pd_next, mask_reg, mask_next;

  always_comb begin
    pd_next   = pd_reg;
    mask_next = mask_reg;
    if (decode_en) begin
      case (f_cmd)
        CMD_PWR:       pd_next = (pd_reg & ~sel) | (sel & {2{|f_data[1:0]}});
        CMD_SW_RST:    if (addr_ok && f_data[0]) begin
                         pd_next   = '0;
                         mask_next = '0;
                       end
        CMD_LDAC_MASK: mask_next = f_data[1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      pd_reg   <= '0;
      mask_reg <= '0;
    end else begin
      pd_reg   <= pd_next;
      mask_reg <= mask_next;
    end
  end

  // ---------------- per-channel input/DAC registers ----------------
  logic [1:0][15:0] in_q, dac_q;

  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    logic [15:0] in_reg, in_next, dac_reg, dac_next;

    always_comb begin
      in_next  = in_reg;
      dac_next = dac_reg;
      if (decode_en && sel[gi]) begin
        case (f_cmd)
          CMD_WR_IN, CMD_WR_IN_UPD_ALL: in_next = f_data;
          CMD_UPD_DAC: dac_next = in_reg;
          CMD_WR_UPD: begin
            in_next  = f_data;
            dac_next = f_data;
          end
          default: ;
        endcase
      end
      // These two act on both channels once the address is valid at all
      if (decode_en && addr_ok) begin
        if (f_cmd == CMD_WR_IN_UPD_ALL) dac_next = in_next;
        if (f_cmd == CMD_SW_RST) begin
          in_next  = CLR_CODE;
          dac_next = CLR_CODE;
        end
      end
      // LDAC copies the pre-decode IN value; a fresh write reaches DAC one cycle later
      if (ldac_low && !mask_reg[gi]) dac_next = in_reg;
      if (clr_low) begin
        in_next  = CLR_CODE;
        dac_next = CLR_CODE;
      end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
        in_reg  <= CLR_CODE;
        dac_reg <= CLR_CODE;
      end else begin
        in_reg  <= in_next;
        dac_reg <= dac_next;
      end
    end

    assign in_q[gi]  = in_reg;
    assign dac_q[gi] = dac_reg;
  end

  assign in_a      = in_q[0];
  assign in_b      = in_q[1];
  assign dac_a     = dac_q[0];
  assign dac_b     = dac_q[1];
  assign pd_mode   = pd_reg;
  assign ldac_mask = mask_reg;

endmodule

// File: tb/tb_dac8563_spi_rx_decoder.sv
// Self-checking bench for dac8563_spi_rx_decoder: directed vector table,
// hand-written corner sequences and randomized frames against a behavioural
// model of the DAC register map.
module tb_dac8563_spi_rx_decoder;
  import dac8563_spi_rx_decoder_pkg::*;

  localparam int          SS   = 2;
  localparam int          HALF = 4;       // sys clocks per SCLK half period
  localparam logic [15:0] CLRV = 16'h8000;

  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;
  always #5 sys_clk = ~sys_clk;

  dac8563_spi_rx_decoder_if spi_bus ();

  logic [15:0] dac_a, dac_b, in_a, in_b, frame_data;
  logic [1:0]  pd_mode, ldac_mask;
  logic        frame_vld, frame_err;
  logic [2:0]  frame_cmd, frame_addr;

  dac8563_spi_rx_decoder #(.SYNC_STAGES(SS), .CLR_CODE(CLRV)) dut (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .spi        (spi_bus),
    .dac_a      (dac_a),
    .dac_b      (dac_b),
    .in_a       (in_a),
    .in_b       (in_b),
    .pd_mode    (pd_mode),
    .ldac_mask  (ldac_mask),
    .frame_vld  (frame_vld),
    .frame_cmd  (frame_cmd),
    .frame_addr (frame_addr),
    .frame_data (frame_data),
    .frame_err  (frame_err)
  );

  int errors = 0;
  int checks = 0;
  int vld_cnt = 0;
  int err_cnt = 0;

  always @(negedge sys_clk) begin
    if (frame_vld === 1'b1) vld_cnt++;
    if (frame_err === 1'b1) err_cnt++;
  end

  // ---------------- behavioural model ----------------
  logic [15:0] m_in [2];
  logic [15:0] m_dac [2];
  logic [1:0]  m_pd, m_mask;

  task automatic model_reset();
    for (int ch = 0; ch < 2; ch++) begin
      m_in[ch]  = CLRV;
      m_dac[ch] = CLRV;
    end
    m_pd   = 2'b00;
    m_mask = 2'b00;
  endtask

  task automatic model_frame(input logic [2:0] c, input logic [2:0] a,
                             input logic [15:0] d, input bit clr_active);
    bit targ [2];
    bit ok;
    targ[0] = (a == 3'd0) || (a == 3'd7);
    targ[1] = (a == 3'd1) || (a == 3'd7);
    ok = targ[0] || targ[1];
    for (int ch = 0; ch < 2; ch++) begin
      if (targ[ch]) begin
        case (c)
          3'd0: m_in[ch] = d;
          3'd1: m_dac[ch] = m_in[ch];
          3'd2: m_in[ch] = d;
          3'd3: begin m_in[ch] = d; m_dac[ch] = d; end
          3'd4: m_pd[ch] = (d[1:0] != 2'b00);
          default: ;
        endcase
      end
    end
    if (c == 3'd2 && ok)
      for (int ch = 0; ch < 2; ch++) m_dac[ch] = m_in[ch];
    if (c == 3'd5 && ok) begin
      for (int ch = 0; ch < 2; ch++) begin m_in[ch] = CLRV; m_dac[ch] = CLRV; end
      if (d[0]) begin m_pd = 2'b00; m_mask = 2'b00; end
    end
    if (c == 3'd6) m_mask = d[1:0];
    if (clr_active)
      for (int ch = 0; ch < 2; ch++) begin m_in[ch] = CLRV; m_dac[ch] = CLRV; end
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, " in_a"},      32'(in_a),      32'(m_in[0]));
    check({tag, " in_b"},      32'(in_b),      32'(m_in[1]));
    check({tag, " dac_a"},     32'(dac_a),     32'(m_dac[0]));
    check({tag, " dac_b"},     32'(dac_b),     32'(m_dac[1]));
    check({tag, " pd_mode"},   32'(pd_mode),   32'(m_pd));
    check({tag, " ldac_mask"}, 32'(ldac_mask), 32'(m_mask));
  endtask

  // ---------------- pin drivers ----------------
  task automatic half_sclk();
    repeat (HALF) @(posedge sys_clk);
    #1;
  endtask

  // Shifts bits [first, last) of a frame; bit 23 is the committing edge, after
  // which the cycles to frame_vld are counted (0 = never seen within budget).
  task automatic shift_bits(input logic [23:0] w, input int first, input int last,
                            input bit clr_at_end, output int lat);
    lat = 0;
    for (int i = first; i < last; i++) begin
      spi_bus.mosi = (i < 24) ? w[23 - i] : 1'($urandom);
      spi_bus.sclk = 1'b1;
      half_sclk();
      spi_bus.sclk = 1'b0;
      if (i == 23) begin
        if (clr_at_end) spi_bus.clr = 1'b0;
        for (int k = 1; k <= 12; k++) begin
          @(posedge sys_clk);
          #1;
          if (frame_vld === 1'b1 && lat == 0) lat = k;
        end
        spi_bus.clr = 1'b1;
      end else begin
        half_sclk();
      end
    end
  endtask

  task automatic send_frame(input logic [23:0] w, input int nbits, input int extra,
                            input bit clr_at_end, output int lat);
    spi_bus.sync = 1'b0;
    half_sclk();
    shift_bits(w, 0, nbits + extra, clr_at_end, lat);
    spi_bus.sclk = 1'b1;
    half_sclk();
    spi_bus.sync = 1'b1;
    repeat (3 * HALF) @(posedge sys_clk);
    #1;
  endtask

  task automatic run_frame(input string tag, input logic [2:0] c, input logic [2:0] a,
                           input logic [15:0] d, input int extra, input bit clr_end);
    int v0, e0, lat;
    v0 = vld_cnt;
    e0 = err_cnt;
    send_frame({2'($urandom), c, a, d}, 24, extra, clr_end, lat);
    model_frame(c, a, d, clr_end);
    check({tag, " vld pulses"}, 32'(vld_cnt - v0), 32'd1);
    check({tag, " err pulses"}, 32'(err_cnt - e0), 32'd0);
    check({tag, " latency"},    32'(lat),          32'(SS + 2));
    check({tag, " frame_cmd"},  32'(frame_cmd),    32'(c));
    check({tag, " frame_addr"}, 32'(frame_addr),   32'(a));
    check({tag, " frame_data"}, 32'(frame_data),   32'(d));
    $display("%s: frame cmd=%0d addr=%0d data=%h extra=%0d clr=%0d latency=%0d",
             tag, c, a, d, extra, clr_end, lat);
  endtask

  task automatic run_partial(input string tag, input int nbits);
    int v0, e0, lat;
    v0 = vld_cnt;
    e0 = err_cnt;
    send_frame(24'($urandom), nbits, 0, 1'b0, lat);
    check({tag, " vld pulses"}, 32'(vld_cnt - v0), 32'd0);
    check({tag, " err pulses"}, 32'(err_cnt - e0), (nbits > 0) ? 32'd1 : 32'd0);
    check_model(tag);
    $display("%s: partial frame of %0d bits", tag, nbits);
  endtask

  task automatic ldac_pulse(input int cycles);
    spi_bus.ldac = 1'b0;
    repeat (cycles) @(posedge sys_clk);
    spi_bus.ldac = 1'b1;
    repeat (6) @(posedge sys_clk);
    #1;
    for (int ch = 0; ch < 2; ch++) if (!m_mask[ch]) m_dac[ch] = m_in[ch];
  endtask

  task automatic clr_pulse();
    spi_bus.clr = 1'b0;
    repeat (10) @(posedge sys_clk);
    spi_bus.clr = 1'b1;
    repeat (6) @(posedge sys_clk);
    #1;
    for (int ch = 0; ch < 2; ch++) begin m_in[ch] = CLRV; m_dac[ch] = CLRV; end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [2:0]  cmd;
    logic [2:0]  addr;
    logic [15:0] data;
    bit          ldac;
    logic [15:0] e_in_a, e_in_b, e_dac_a, e_dac_b;
    logic [1:0]  e_pd, e_mask;
  } vec_t;

  vec_t vecs [14];

  initial begin
    int lat, v0, e0;

    vecs[0]  = '{3'd3, 3'd0, 16'h1234, 1'b0, 16'h1234, 16'h8000, 16'h1234, 16'h8000, 2'b00, 2'b00};
    vecs[1]  = '{3'd0, 3'd7, 16'hFFFF, 1'b0, 16'hFFFF, 16'hFFFF, 16'h1234, 16'h8000, 2'b00, 2'b00};
    vecs[2]  = '{3'd7, 3'd0, 16'h0000, 1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 2'b00, 2'b00};
    vecs[3]  = '{3'd6, 3'd5, 16'h0001, 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 2'b00, 2'b01};
    vecs[4]  = '{3'd0, 3'd0, 16'h0AAA, 1'b0, 16'h0AAA, 16'hFFFF, 16'hFFFF, 16'hFFFF, 2'b00, 2'b01};
    vecs[5]  = '{3'd0, 3'd1, 16'h0AAA, 1'b1, 16'h0AAA, 16'h0AAA, 16'hFFFF, 16'h0AAA, 2'b00, 2'b01};
    vecs[6]  = '{3'd4, 3'd1, 16'h0003, 1'b0, 16'h0AAA, 16'h0AAA, 16'hFFFF, 16'h0AAA, 2'b10, 2'b01};
    vecs[7]  = '{3'd4, 3'd0, 16'h0002, 1'b0, 16'h0AAA, 16'h0AAA, 16'hFFFF, 16'h0AAA, 2'b11, 2'b01};
    vecs[8]  = '{3'd1, 3'd0, 16'h9999, 1'b0, 16'h0AAA, 16'h0AAA, 16'h0AAA, 16'h0AAA, 2'b11, 2'b01};
    vecs[9]  = '{3'd2, 3'd1, 16'h5555, 1'b0, 16'h0AAA, 16'h5555, 16'h0AAA, 16'h5555, 2'b11, 2'b01};
    vecs[10] = '{3'd3, 3'd4, 16'h1111, 1'b0, 16'h0AAA, 16'h5555, 16'h0AAA, 16'h5555, 2'b11, 2'b01};
    vecs[11] = '{3'd5, 3'd0, 16'h0000, 1'b0, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 2'b11, 2'b01};
    vecs[12] = '{3'd5, 3'd7, 16'h0001, 1'b0, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 2'b00, 2'b00};
    vecs[13] = '{3'd3, 3'd7, 16'hABCD, 1'b1, 16'hABCD, 16'hABCD, 16'hABCD, 16'hABCD, 2'b00, 2'b00};

    spi_bus.sync = 1'b1;
    spi_bus.sclk = 1'b1;
    spi_bus.mosi = 1'b0;
    spi_bus.ldac = 1'b1;
    spi_bus.clr  = 1'b1;
    model_reset();

    // Reset state
    repeat (3) @(posedge sys_clk);
    #1;
    check_model("reset");
    check("reset frame_vld",  32'(frame_vld),  32'd0);
    check("reset frame_err",  32'(frame_err),  32'd0);
    check("reset frame_cmd",  32'(frame_cmd),  32'd0);
    check("reset frame_data", 32'(frame_data), 32'd0);
    rst_n = 1'b1;
    repeat (6) @(posedge sys_clk);
    #1;

    // Directed table
    for (int i = 0; i < 14; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      run_frame(tag, vecs[i].cmd, vecs[i].addr, vecs[i].data, 0, 1'b0);
      if (vecs[i].ldac) ldac_pulse(100);
      check({tag, " in_a"},      32'(in_a),      32'(vecs[i].e_in_a));
      check({tag, " in_b"},      32'(in_b),      32'(vecs[i].e_in_b));
      check({tag, " dac_a"},     32'(dac_a),     32'(vecs[i].e_dac_a));
      check({tag, " dac_b"},     32'(dac_b),     32'(vecs[i].e_dac_b));
      check({tag, " pd_mode"},   32'(pd_mode),   32'(vecs[i].e_pd));
      check({tag, " ldac_mask"}, 32'(ldac_mask), 32'(vecs[i].e_mask));
    end

    // Aborted frames: 13 bits gives an error pulse, an empty frame is silent
    run_partial("abort13", 13);
    run_partial("abort0", 0);
    run_frame("after_abort", 3'd0, 3'd1, 16'h2468, 0, 1'b0);
    check_model("after_abort");

    // Over-long frames: edges past 24 ignored; CLR during decode wins
    run_frame("long26", 3'd3, 3'd0, 16'h4321, 2, 1'b0);
    check_model("long26");
    run_frame("long26_clr", 3'd3, 3'd7, 16'h1234, 2, 1'b1);
    check_model("long26_clr");

    // Randomized traffic against the model
    for (int t = 0; t < 40; t++) begin
      int kind;
      string tag;
      logic [2:0] c, a;
      tag  = $sformatf("rnd%0d", t);
      kind = $urandom_range(0, 9);
      c = 3'($urandom);
      case ($urandom_range(0, 3))
        0: a = 3'd0;
        1: a = 3'd1;
        2: a = 3'd7;
        default: a = 3'($urandom);
      endcase
      if (kind == 0) begin
        run_partial(tag, $urandom_range(1, 23));
      end else if (kind == 1) begin
        ldac_pulse($urandom_range(4, 30));
        check_model(tag);
        $display("%s: ldac pulse", tag);
      end else if (kind == 2) begin
        clr_pulse();
        check_model(tag);
        $display("%s: clr pulse", tag);
      end else begin
        run_frame(tag, c, a, 16'($urandom), $urandom_range(0, 2), (kind == 3));
        check_model(tag);
      end
    end

    // Reset asserted and released in the middle of a frame
    run_frame("pre_rst_pd",   3'd4, 3'd7, 16'h0001, 0, 1'b0);
    run_frame("pre_rst_mask", 3'd6, 3'd0, 16'h0003, 0, 1'b0);
    run_frame("pre_rst_wr",   3'd3, 3'd7, 16'h5A5A, 0, 1'b0);
    v0 = vld_cnt;
    e0 = err_cnt;
    spi_bus.sync = 1'b0;
    half_sclk();
    shift_bits({2'b00, 3'd3, 3'd7, 16'h0F0F}, 0, 10, 1'b0, lat);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_model("rst_async");
    check("rst_async frame_data", 32'(frame_data), 32'd0);
    repeat (3) @(posedge sys_clk);
    #3;
    rst_n = 1'b1;
    shift_bits({2'b00, 3'd3, 3'd7, 16'h0F0F}, 10, 24, 1'b0, lat);
    spi_bus.sclk = 1'b1;
    half_sclk();
    spi_bus.sync = 1'b1;
    repeat (3 * HALF) @(posedge sys_clk);
    #1;
    check("rst_mid vld pulses", 32'(vld_cnt - v0), 32'd0);
    check("rst_mid err pulses", 32'(err_cnt - e0), 32'd0);
    check("rst_mid frame_cmd",  32'(frame_cmd),    32'd0);
    check_model("rst_mid");
    $display("rst_mid: reset during frame, remainder dropped");
    run_frame("post_rst", 3'd3, 3'd1, 16'h7E57, 0, 1'b0);
    check_model("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
